// File: rtl/i2c_master_param.sv
// i2c_master_param: byte-command I2C master with internal SCL divider, clock stretching and sticky NACK error.
module i2c_master_param #(
    parameter int CLK_DIV    = 125,
    parameter int DIV_W      = 8,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_rw,
    input  logic       ack_o,
    input  logic [7:0] out_byte,
    output logic [7:0] in_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       held,
    output logic       err,
    input  logic       scl_i,
    output logic       scl_oe,
    input  logic       sda_i,
    output logic       sda_oe
);
    typedef enum logic [3:0] {IDLE, HOLD, START_A, START_B, BIT, ACK, STOP_A, STOP_B, STOP_C} state_t;
    state_t state, nxt;
    logic [DIV_W-1:0] cnt;
    logic [1:0] q;
    logic [2:0] bit_cnt;
    logic [7:0] sh;
    logic rw, stop, ack;
    logic accept, frz, tick;
    assign cmd_ready = (state == IDLE) || (state == HOLD);
    assign busy = !cmd_ready;
    assign accept = cmd_valid && cmd_ready;
    // divider freezes only while SCL is released and a slave keeps it low
    assign frz = STRETCH_EN && !scl_i &&
                 (state == STOP_B || (q == 2'd1 && (state == START_A || state == BIT || state == ACK)));
    assign tick = (cnt == DIV_W'(CLK_DIV - 1)) && !frz;
    always_comb begin
        nxt = state;
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            IDLE: if (accept && cmd_start) nxt = START_B;
            HOLD: begin
                scl_oe = 1'b1;
                if (accept) nxt = cmd_start ? START_A : BIT;
            end
            START_A: begin
                scl_oe = (q == 2'd0);
                if (tick && q == 2'd1) nxt = START_B;
            end
            START_B: begin
                scl_oe = (q == 2'd1);
                sda_oe = 1'b1;
                if (tick && q == 2'd1) nxt = BIT;
            end
            BIT: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = !rw && !sh[7];
                if (tick && q == 2'd3 && bit_cnt == 3'd0) nxt = ACK;
            end
            ACK: begin
                scl_oe = (q == 2'd0) || (q == 2'd3);
                sda_oe = rw && !ack;
                if (tick && q == 2'd3) nxt = stop ? STOP_A : HOLD;
            end
            STOP_A: begin
                scl_oe = 1'b1;
                sda_oe = 1'b1;
                if (tick) nxt = STOP_B;
            end
            STOP_B: begin
                sda_oe = 1'b1;
                if (tick) nxt = STOP_C;
            end
            STOP_C: if (tick) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            q <= 2'd0;
            bit_cnt <= 3'd0;
            sh <= 8'd0;
            rw <= 1'b0;
            stop <= 1'b0;
            ack <= 1'b0;
            held <= 1'b0;
            err <= 1'b0;
            in_byte <= 8'd0;
            rx_valid <= 1'b0;
        end else begin
            state <= nxt;
            rx_valid <= 1'b0;
            if (nxt != state || tick) begin
                cnt <= '0;
                q <= (nxt != state) ? 2'd0 : q + 2'd1;
            end else if (!frz) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                rw <= cmd_rw;
                stop <= cmd_stop;
                ack <= ack_o;
                sh <= out_byte;
                bit_cnt <= 3'd7;
                if (cmd_start) begin
                    err <= 1'b0;
                    held <= 1'b1;
                end else if (state == IDLE) begin
                    err <= 1'b1;
                end
            end
            // reads shift in at the q2->q3 edge; writes shift out after q3 so SDA holds all bit long
            if (tick && state == BIT && q == 2'd2 && rw) sh <= {sh[6:0], sda_i};
            if (tick && state == BIT && q == 2'd3) begin
                bit_cnt <= bit_cnt - 3'd1;
                if (!rw) sh <= {sh[6:0], 1'b0};
            end
            if (tick && state == ACK && q == 2'd2 && !rw && sda_i) err <= 1'b1;
            if (tick && state == ACK && q == 2'd3 && rw) begin
                in_byte <= sh;
                rx_valid <= 1'b1;
            end
            if (tick && state == STOP_C) held <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2c_master_param.sv
// tb_i2c_master_param: directed checks of the I2C master against a small bus/slave model.
module tb_i2c_master_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_rw = 1'b0, ack_o = 1'b0;
    logic [7:0] out_byte = 8'd0;
    logic cmd_ready, rx_valid, busy, held, err, scl_oe, sda_oe;
    logic [7:0] in_byte;
    logic scl, sda, sda_pull;
    logic sl_scl = 1'b0, sl_rd = 1'b0, sl_ack = 1'b0;
    logic [7:0] sl_tx = 8'd0;
    logic scl_q = 1'b1, sda_q = 1'b1;
    logic [9:0] mon = 10'd0;
    int fl = 0, starts = 0, stops = 0, rx_cnt = 0;
    int n_cmp = 0, n_bad = 0;
    int n, st0, sp0, rx0;

    i2c_master_param #(.CLK_DIV(4), .DIV_W(4), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_rw(cmd_rw), .ack_o(ack_o),
        .out_byte(out_byte), .in_byte(in_byte), .rx_valid(rx_valid), .busy(busy),
        .held(held), .err(err), .scl_i(scl), .scl_oe(scl_oe), .sda_i(sda), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;
    assign scl = !scl_oe && !sl_scl;
    assign sda = !sda_oe && !sda_pull;
    // slave presents read bit k after the k-th SCL fall since START; ACKs a write on the 9th fall
    always_comb sda_pull = sl_rd ? (fl >= 1 && fl <= 8 && !sl_tx[3'(8 - fl)]) : (sl_ack && fl == 9);

    always @(posedge clk) begin
        scl_q <= scl;
        sda_q <= sda;
        if (scl && scl_q && sda_q && !sda) begin
            starts <= starts + 1;
            fl <= 0;
        end else if (!scl && scl_q) begin
            fl <= fl + 1;
        end
        if (scl && !scl_q) mon <= {mon[8:0], sda};
        if (scl && scl_q && !sda_q && sda) stops <= stops + 1;
        if (rx_valid) rx_cnt <= rx_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic st, input logic sp, input logic r, input logic a, input logic [7:0] b);
        @(negedge clk);
        cmd_start = st;
        cmd_stop = sp;
        cmd_rw = r;
        ack_o = a;
        out_byte = b;
        cmd_valid = 1'b1;
        chk("ready_before_accept", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n0, output int nn);
        nn = n0;
        do begin
            @(posedge clk);
            #1 nn++;
        end while (busy && nn < 2000);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_held", held, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_in_byte", in_byte, 0);
        @(negedge clk) rst = 1'b0;

        send(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("illegal_err", err, 1);
        chk("illegal_ready", cmd_ready, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_held", held, 0);

        sl_ack = 1'b1;
        st0 = starts;
        sp0 = stops;
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        chk("wr_busy", busy, 1);
        chk("wr_ready_drop", cmd_ready, 0);
        chk("wr_err_cleared", err, 0);
        wait_idle(0, n);
        chk("wr_hold_latency", n, 152);
        chk("wr_sda_bits", mon[8:1], 8'hAA);
        chk("wr_ack_bit", mon[0], 0);
        chk("wr_err", err, 0);
        chk("wr_held", held, 1);
        chk("wr_scl_low_hold", scl_oe, 1);
        chk("wr_start_seen", starts, st0 + 1);
        chk("wr_no_stop", stops, sp0);

        sl_ack = 1'b0;
        sp0 = stops;
        send(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        wait_idle(0, n);
        chk("nack_latency", n, 156);
        chk("nack_sda_bits", mon[9:2], 8'h3C);
        chk("nack_ack_bit", mon[1], 1);
        chk("nack_err", err, 1);
        chk("nack_stop_seen", stops, sp0 + 1);
        chk("nack_held", held, 0);
        repeat (3) @(posedge clk);
        #1 chk("nack_err_sticky", err, 1);

        sl_ack = 1'b1;
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
        chk("a0_err_cleared", err, 0);
        wait_idle(0, n);
        chk("a0_latency", n, 152);
        chk("a0_sda_bits", mon[8:1], 8'hA0);
        chk("a0_held", held, 1);

        sl_rd = 1'b1;
        sl_tx = 8'h5C;
        st0 = starts;
        sp0 = stops;
        rx0 = rx_cnt;
        send(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        repeat (16) @(posedge clk);
        #1;
        chk("rs_start_seen", starts, st0 + 1);
        chk("rs_no_stop_between", stops, sp0);
        wait_idle(16, n);
        chk("rd_latency", n, 172);
        chk("rd_in_byte", in_byte, 8'h5C);
        chk("rd_rx_pulses", rx_cnt, rx0 + 1);
        chk("rd_sda_bits", mon[9:2], 8'h5C);
        chk("rd_nack_released", mon[1], 1);
        chk("rd_stop_seen", stops, sp0 + 1);
        chk("rd_held", held, 0);
        chk("rd_err", err, 0);
        sl_rd = 1'b0;

        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h96);
        repeat (59) @(posedge clk);
        @(negedge clk) sl_scl = 1'b1;
        repeat (51) @(posedge clk);
        @(negedge clk) sl_scl = 1'b0;
        wait_idle(110, n);
        chk("stretch_latency", n, 202);
        chk("stretch_sda_bits", mon[8:1], 8'h96);
        chk("stretch_ack_bit", mon[0], 0);
        chk("stretch_held", held, 1);

        sp0 = stops;
        send(1'b0, 1'b0, 1'b0, 1'b0, 8'hAA);
        repeat (81) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_scl_oe", scl_oe, 0);
        chk("mid_rst_sda_oe", sda_oe, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_held", held, 0);
        chk("mid_rst_in_byte", in_byte, 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("mid_rst_no_stop", stops, sp0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_master_param.md
Name: i2c_master_param

Overview:
Byte-oriented, single-clock I2C master, parametrised successor to I2C_Top.
- Derives SCL internally from `clk` through a programmable divider, so no separate frame clock is needed.
- Accepts a stream of byte commands through a valid/ready handshake: START / repeated-START, write, read with selectable ACK, and STOP.
- Supports multi-byte transactions, slave clock stretching and a sticky NACK error.
- Sits between sensor/control FSMs and the open-drain SCL/SDA pads.

Parameters:
- CLK_DIV, 125, `clk` cycles per SCL quarter-period (min 2); SCL period = 4*CLK_DIV with no stretching.
- DIV_W, 8, divider counter width; must satisfy 2^DIV_W > CLK_DIV.
- STRETCH_EN, 1, 1 = honour slave clock stretching on scl_i; 0 = ignore scl_i.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_start  in  1  issue START (repeated START if bus already held) before the byte
- cmd_stop  in  1  issue STOP after the byte
- cmd_rw  in  1  0 = write out_byte, 1 = read into in_byte
- ack_o  in  1  ACK bit driven after a read (0 = ACK, 1 = NACK)
- out_byte  in  8  byte to transmit, MSB first
- in_byte  out  8  last received byte
- rx_valid  out  1  1-cycle pulse when in_byte updates
- busy  out  1  high from command acceptance until the bus is released or held
- held  out  1  bus owned (START issued, STOP not yet issued)
- err  out  1  sticky: slave NACK on a write; cleared by the next accepted cmd_start
- scl_i  in  1  SCL pad input
- scl_oe  out  1  1 = pull SCL low
- sda_i  in  1  SDA pad input
- sda_oe  out  1  1 = pull SDA low

Behaviour:
- Reset: scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, held=0, err=0, rx_valid=0, in_byte=0. The divider clears and the FSM enters IDLE.
- Reset mid-operation releases both lines within the same cycle. No STOP is generated.
- Quarter tick: fires every CLK_DIV clocks. The divider restarts on every state entry.
- States: IDLE, HOLD, START_A, START_B, BIT, ACK, STOP_A, STOP_B, STOP_C.
- Handshake: cmd_ready=1 only in IDLE or HOLD. Command fields are latched on acceptance; cmd_ready drops the next cycle. A command in IDLE with cmd_start=0 is illegal: it sets err, is dropped, and cmd_ready stays 1.
- Accepted command with cmd_start=1:
  - START_A: release SDA for 1 quarter, then release SCL for 1 quarter.
  - START_B: sda_oe=1 for 1 quarter, then scl_oe=1.
  - Without cmd_start, go straight to BIT.
- BIT, per bit, 4 quarters:
  - q0: SCL low; drive SDA. sda_oe = ~bit on write, 0 on read.
  - q1: release SCL.
  - q2: SCL high.
  - q3: sample sda_i at entry; pull SCL low.
- ACK: same 4 quarters as a bit.
  - Write: release SDA and sample; sda_i=1 sets err.
  - Read: drive ack_o, then load in_byte and pulse rx_valid at q3 end.
- After ACK:
  - cmd_stop=1 → STOP sequence: SDA low, SCL release, SDA release (1 quarter each), then IDLE with held=0.
  - cmd_stop=0 → HOLD with SCL low, SDA released, held=1, busy=0.
- Clock stretching (STRETCH_EN=1): after SCL is released (START_A, q1, STOP_B), the divider is frozen while scl_i=0. Counting resumes the cycle after scl_i=1.
- Data bits go MSB first. A write NACK does not abort the command: the STOP still executes if requested.
- Simultaneous cmd_valid and rst: rst wins.

Test Plan:
- Write 0xAA with cmd_start=1, cmd_stop=0, slave ACK, CLK_DIV=4 → SDA pattern 1,0,1,0,1,0,1,0 sampled on SCL rises; err=0; held=1; HOLD reached 36*4+8 clks after acceptance.
- Same write with sda_i=1 at ACK → err=1. It stays 1 through a following STOP and clears on the next cmd_start.
- Read with slave driving 0x5C and ack_o=1, cmd_stop=1 → in_byte=0x5C, one rx_valid pulse, SDA released at ACK, STOP seen (SDA rises while SCL high), held=0.
- Write 0xA0, then a second command with cmd_start=1 and cmd_rw=1 → repeated START (SDA falls while SCL high) with no STOP between.
- Slave holds scl_i=0 for 50 clks at bit 3 q1 → that bit lengthens by exactly 50 clks; data intact.
- rst asserted at bit 5 of a write → next cycle scl_oe=0, sda_oe=0, cmd_ready=1, busy=0.
